// File: rtl/text_cursor_overlay.sv
// Text cursor overlay: one-cycle pixel pipeline stage that paints the hardware text
// cursor (underline / half / block, optional blink, replace or invert) on the renderer stream.
module text_cursor_overlay #(
   parameter int   BPP          = 8,
   parameter int   CHAR_W       = 9,
   parameter int   CHAR_H       = 16,
   parameter int   COLS         = 80,
   parameter int   ROWS         = 25,
   parameter logic VS_POL       = 1'b1,
   parameter int   BLINK_FRAMES = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            blank_n_i,
   input  logic            hs_i,
   input  logic            vs_i,
   input  logic [BPP-1:0]  red_i,
   input  logic [BPP-1:0]  green_i,
   input  logic [BPP-1:0]  blue_i,
   input  logic [31:0]     cursorpos,
   input  logic [3:0]      cursormode,
   input  logic [23:0]     cursorcolor,
   output logic            blank_n,
   output logic            hs,
   output logic            vs,
   output logic [BPP-1:0]  red,
   output logic [BPP-1:0]  green,
   output logic [BPP-1:0]  blue
);

   localparam int PXW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;
   localparam int SW  = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
   localparam int CW  = $clog2(COLS + 1);
   localparam int RW  = $clog2(ROWS + 1);
   localparam int BFW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PXW-1:0] PX_LAST    = PXW'(CHAR_W - 1);
   localparam logic [SW-1:0]  SCAN_LAST  = SW'(CHAR_H - 1);
   localparam logic [SW-1:0]  SCAN_UL    = SW'(CHAR_H - 2);
   localparam logic [SW-1:0]  SCAN_HALF  = SW'(CHAR_H / 2);
   localparam logic [CW-1:0]  COL_SAT    = CW'(COLS);
   localparam logic [RW-1:0]  ROW_SAT    = RW'(ROWS);
   localparam logic [BFW-1:0] BLINK_LAST = BFW'(BLINK_FRAMES - 1);

   // Pipeline registers (also serve as the previous-sample history for edge detection)
   logic            blank_n_q, hs_q, vs_q;
   logic [BPP-1:0]  red_q, green_q, blue_q;
   logic [BPP-1:0]  red_d, green_d, blue_d;

   // Beam position counters
   logic [PXW-1:0]  px_q, px_d;
   logic [CW-1:0]   col_q, col_d;
   logic [SW-1:0]   scan_q, scan_d;
   logic [RW-1:0]   row_q, row_d;

   // Blink state
   logic [BFW-1:0]  blink_cnt_q, blink_cnt_d;
   logic            blink_hide_q, blink_hide_d;

   // Cursor shadow, loaded only at frame start so a frame is never torn
   logic [7:0]      sh_col_q, sh_row_q;
   logic [3:0]      sh_mode_q;
   logic [23:0]     sh_color_q;

   logic            frame_start;
   logic            line_end;
   logic            shape_hit;
   logic            pos_hit;
   logic            cursor_on;
   logic            unused_pos;

   assign unused_pos  = ^cursorpos[31:16];

   assign frame_start = (vs_i == VS_POL) && (vs_q != VS_POL);
   assign line_end    = !blank_n_i && blank_n_q;

   always_comb begin
      px_d  = px_q;
      col_d = col_q;
      if (!blank_n_i) begin
         px_d  = '0;
         col_d = '0;
      end else if (px_q == PX_LAST) begin
         px_d = '0;
         if (col_q != COL_SAT) begin
            col_d = col_q + 1'b1;
         end
      end else begin
         px_d = px_q + 1'b1;
      end
   end

   always_comb begin
      scan_d = scan_q;
      row_d  = row_q;
      if (frame_start) begin
         scan_d = '0;
         row_d  = '0;
      end else if (line_end) begin
         if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            if (row_q != ROW_SAT) begin
               row_d = row_q + 1'b1;
            end
         end else begin
            scan_d = scan_q + 1'b1;
         end
      end
   end

   always_comb begin
      blink_cnt_d  = blink_cnt_q;
      blink_hide_d = blink_hide_q;
      if (frame_start) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d  = '0;
            blink_hide_d = !blink_hide_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      shape_hit = 1'b0;
      case (sh_mode_q[1:0])
         2'd0: shape_hit = 1'b0;
         2'd1: shape_hit = (scan_q >= SCAN_UL);
         2'd2: shape_hit = 1'b1;
         2'd3: shape_hit = (scan_q >= SCAN_HALF);
         default: shape_hit = 1'b0;
      endcase
   end

   // Saturated counters sit at COLS/ROWS, so the range guard keeps them from ever matching
   assign pos_hit = (col_q < COL_SAT) && (row_q < ROW_SAT) &&
                    (32'(col_q) == 32'(sh_col_q)) &&
                    (32'(row_q) == 32'(sh_row_q));

   assign cursor_on = blank_n_i && pos_hit && shape_hit &&
                      (!sh_mode_q[2] || !blink_hide_q);

   always_comb begin
      red_d   = red_i;
      green_d = green_i;
      blue_d  = blue_i;
      if (cursor_on) begin
         if (sh_mode_q[3]) begin
            red_d   = ~red_i;
            green_d = ~green_i;
            blue_d  = ~blue_i;
         end else begin
            red_d   = sh_color_q[23 -: BPP];
            green_d = sh_color_q[15 -: BPP];
            blue_d  = sh_color_q[7 -: BPP];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blank_n_q    <= 1'b0;
         hs_q         <= 1'b0;
         vs_q         <= 1'b0;
         red_q        <= '0;
         green_q      <= '0;
         blue_q       <= '0;
         px_q         <= '0;
         col_q        <= '0;
         scan_q       <= '0;
         row_q        <= '0;
         blink_cnt_q  <= '0;
         blink_hide_q <= 1'b0;
         sh_col_q     <= '0;
         sh_row_q     <= '0;
         sh_mode_q    <= '0;
         sh_color_q   <= '0;
      end else begin
         blank_n_q    <= blank_n_i;
         hs_q         <= hs_i;
         vs_q         <= vs_i;
         red_q        <= red_d;
         green_q      <= green_d;
         blue_q       <= blue_d;
         px_q         <= px_d;
         col_q        <= col_d;
         scan_q       <= scan_d;
         row_q        <= row_d;
         blink_cnt_q  <= blink_cnt_d;
         blink_hide_q <= blink_hide_d;
         if (frame_start) begin
            sh_col_q   <= cursorpos[7:0];
            sh_row_q   <= cursorpos[15:8];
            sh_mode_q  <= cursormode;
            sh_color_q <= cursorcolor;
         end
      end
   end

   assign blank_n = blank_n_q;
   assign hs      = hs_q;
   assign vs      = vs_q;
   assign red     = red_q;
   assign green   = green_q;
   assign blue    = blue_q;

endmodule

// File: tb/tb_text_cursor_overlay.sv
// Directed bench for text_cursor_overlay: every output cycle is compared against a
// reference built from beam position (x / line number), not from counters.
module tb_text_cursor_overlay;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        blank_n_i, hs_i, vs_i;
   logic [7:0]  red_i, green_i, blue_i;
   logic [31:0] cursorpos;
   logic [3:0]  cursormode;
   logic [23:0] cursorcolor;
   logic        blank_n, hs, vs;
   logic [7:0]  red, green, blue;

   text_cursor_overlay #(
      .BPP(8), .CHAR_W(9), .CHAR_H(16), .COLS(80), .ROWS(25),
      .VS_POL(1'b1), .BLINK_FRAMES(2)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .blank_n_i(blank_n_i), .hs_i(hs_i), .vs_i(vs_i),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .cursorpos(cursorpos), .cursormode(cursormode), .cursorcolor(cursorcolor),
      .blank_n(blank_n), .hs(hs), .vs(vs),
      .red(red), .green(green), .blue(blue)
   );

   always #5 clk_i = ~clk_i;

   int          n_checks = 0;
   int          n_fail   = 0;
   string       tag;
   logic [26:0] exp_v;

   // Reference state: what the cursor shadow should hold and where the beam is
   int          line_no;
   int          starts;
   logic [7:0]  m_col, m_row;
   logic [3:0]  m_mode;
   logic [23:0] m_color;
   logic [23:0] pix_fixed;
   bit          pix_use_fixed;

   task automatic tick();
      @(posedge clk_i);
      #1;
      n_checks++;
      assert ({blank_n, hs, vs, red, green, blue} === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (frame line %0d)", tag,
                {blank_n, hs, vs, red, green, blue}, exp_v, line_no);
      end
   endtask

   // Blink half-period of 2 frames; the post-reset frame counts as the first one,
   // so visibility by frame-start number runs vis, hid, hid, vis, vis, hid, ...
   function automatic bit model_active(int ln, int x);
      int scan;
      bit hit;
      bit vis;
      scan = ln % 16;
      case (m_mode[1:0])
         2'd1:    hit = (scan >= 14);
         2'd2:    hit = 1'b1;
         2'd3:    hit = (scan >= 8);
         default: hit = 1'b0;
      endcase
      vis = ((starts % 4) == 0) || ((starts % 4) == 1);
      return (int'(m_col) < 80) && (int'(m_row) < 25) &&
             ((x / 9) == int'(m_col)) && ((ln / 16) == int'(m_row)) &&
             hit && (!m_mode[2] || vis);
   endfunction

   task automatic drive(bit bn, bit h, bit v, logic [23:0] c, bit cur);
      logic [23:0] o;
      blank_n_i = bn;
      hs_i      = h;
      vs_i      = v;
      {red_i, green_i, blue_i} = c;
      o = cur ? (m_mode[3] ? ~c : m_color) : c;
      exp_v = {bn, h, v, o};
      tick();
   endtask

   task automatic frame_start_model();
      line_no = 0;
      starts++;
      m_col   = cursorpos[7:0];
      m_row   = cursorpos[15:8];
      m_mode  = cursormode;
      m_color = cursorcolor;
   endtask

   // n_act active pixels, then 4 blanking cycles; do_vs raises vsync on the first
   // blanking cycle, coincident with the blank_n falling edge.
   task automatic line(int n_act, bit do_vs);
      logic [23:0] c;
      for (int x = 0; x < n_act; x++) begin
         c = pix_use_fixed ? pix_fixed : {8'(x), 8'(line_no), 8'h5A};
         drive(1'b1, 1'b0, 1'b0, c, model_active(line_no, x));
      end
      if (n_act > 0) line_no++;
      if (do_vs) frame_start_model();
      for (int b = 0; b < 4; b++) begin
         drive(1'b0, (b == 2), do_vs && (b < 2), 24'h0F0F0F ^ 24'(b), 1'b0);
      end
   endtask

   task automatic do_reset();
      tag       = "reset";
      rst_i     = 1'b1;
      blank_n_i = 1'b1;
      hs_i      = 1'b1;
      vs_i      = 1'b0;
      {red_i, green_i, blue_i} = 24'hAABBCC;
      exp_v = '0;
      tick();
      tick();
      rst_i   = 1'b0;
      line_no = 0;
      starts  = 0;
      m_col   = '0;
      m_row   = '0;
      m_mode  = '0;
      m_color = '0;
   endtask

   initial begin
      cursorpos     = 32'h0;
      cursormode    = 4'h0;
      cursorcolor   = 24'h0;
      pix_fixed     = 24'h0;
      pix_use_fixed = 1'b0;
      do_reset();

      // Cursor programmed but no frame start yet: shadow mode 0, nothing drawn
      tag         = "first_frame";
      cursorpos   = 32'h0000_0000;
      cursormode  = 4'b0010;
      cursorcolor = 24'hFF0000;
      line(20, 1'b0);
      line(20, 1'b0);

      tag        = "passthru";
      cursormode = 4'b0000;
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 1'b0);
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 24'h000000, 1'b0);

      // Block at col 3 row 5: x 27..35 on lines 80..95; upper cursorpos bits ignored
      tag         = "block";
      cursorpos   = 32'hABCD_0503;
      cursormode  = 4'b0010;
      cursorcolor = 24'hFF0000;
      line(0, 1'b1);
      for (int l = 0; l < 96; l++) line(40, 1'b0);

      // Underline + invert at col 2 row 1: inverted input on lines 30,31, x 18..26
      tag           = "ul_inv";
      cursorpos     = 32'h0000_0102;
      cursormode    = 4'b1001;
      cursorcolor   = 24'h00FF00;
      pix_fixed     = 24'h123456;
      pix_use_fixed = 1'b1;
      line(0, 1'b1);
      for (int l = 0; l < 32; l++) line(30, 1'b0);
      pix_use_fixed = 1'b0;

      tag         = "bound_col";
      cursorpos   = 32'h0000_0050;
      cursormode  = 4'b0010;
      cursorcolor = 24'h00FF00;
      line(0, 1'b1);
      line(740, 1'b0);
      line(740, 1'b0);

      // Row 25 must stay dark even after the row counter saturates there
      tag       = "bound_row";
      cursorpos = 32'h0000_1900;
      line(0, 1'b1);
      for (int l = 0; l < 410; l++) line(12, 1'b0);

      do_reset();
      tag         = "blink";
      cursorpos   = 32'h0000_0000;
      cursormode  = 4'b0110;
      cursorcolor = 24'h0000FF;
      for (int f = 0; f < 6; f++) begin
         line(0, 1'b1);
         line(12, 1'b0);
         if (f == 3) cursorpos = 32'h0000_0001;
         line(12, 1'b0);
      end

      // Frame start coincident with end of line 15 must win over the scan/row step
      tag        = "simul";
      cursorpos  = 32'h0000_0000;
      cursormode = 4'b0010;
      line(0, 1'b1);
      for (int l = 0; l < 15; l++) line(12, 1'b0);
      line(12, 1'b1);
      line(12, 1'b0);
      line(12, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
